// File: rtl/alu_mult_arbiter_if.sv
// Request, response and ALU-side bundle for alu_mult_arbiter.
// slave = arbiter side, master = issue logic, consumer and ALU.
interface alu_mult_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [2:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             alu_start;
   logic [WIDTH-1:0] alu_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_result, rsp_ready,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_op, alu_start,
      output rsp_valid, rsp_id, rsp_result, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_result, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_op, alu_start,
      input  rsp_valid, rsp_id, rsp_result, busy
   );
endinterface

// File: rtl/alu_mult_arbiter.sv
// Two-requester arbiter/sequencer for the shared alu_with_mult datapath.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_mult_arbiter #(
   parameter int         WIDTH    = 32,
   parameter int         MULT_LAT = 34,
   parameter logic [2:0] MUL_OP   = 3'b010
) (
   input logic               clk,
   input logic               rst,
   alu_mult_arbiter_if.slave bus
);
   localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             gnt0;
   logic             gnt1;
   logic             start;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic             id_q;
   logic [WIDTH-1:0] res_q;
   logic [CW-1:0]    cnt;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
   logic             last_grant;
`endif

   always_comb begin
      state_nx = state;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      start    = 1'b0;
      unique case (state)
         IDLE: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
            // On contention the requester not served last wins.
            gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
            gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
`endif
            if (gnt0 | gnt1)
               state_nx = ISSUE;
         end
         ISSUE: begin
            start    = (op_q == MUL_OP);
            state_nx = WAIT;
         end
         WAIT: begin
            if (cnt == '0)
               state_nx = RESP;
         end
         RESP: begin
            if (bus.rsp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (rst) begin
         state_nx = IDLE;
         gnt0     = 1'b0;
         gnt1     = 1'b0;
         start    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         id_q  <= 1'b0;
         res_q <= '0;
         cnt   <= '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
         last_grant <= 1'b1;
`endif
      end else begin
         if (gnt0 | gnt1) begin
            a_q  <= gnt1 ? bus.req1_a : bus.req0_a;
            b_q  <= gnt1 ? bus.req1_b : bus.req0_b;
            op_q <= gnt1 ? bus.req1_op : bus.req0_op;
            id_q <= gnt1;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
            last_grant <= gnt1;
`endif
         end
         if (state == ISSUE)
            cnt <= start ? CW'(MULT_LAT - 1) : '0;
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == WAIT && cnt == '0)
            res_q <= bus.alu_result;
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_op     = op_q;
   assign bus.alu_start  = start;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_result = res_q;
   assign bus.busy       = (state != IDLE);
endmodule

// File: doc/alu_mult_arbiter.md
# alu_mult_arbiter

Two-requester arbiter and sequencer for the shared `alu_with_mult` datapath. It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU operands and opcode from internal registers, pulses the sequential multiplier's start input and waits out its latency, then returns the tagged result over a valid/ready response port. It sits between the core's issue logic and the single `alu_with_mult` instance.

## Interface
- `WIDTH`, 32: operand/result width (signed, two's complement).
- `MULT_LAT`, 34: cycles from multiplier start pulse to valid `alu_result`; must be ≥1.
- `MUL_OP`, 3'b010: aluop encoding that selects the sequential multiplier.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester n has an operation pending.
- `req0_ready` / `req1_ready`  out  1  requester n's operation is accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_op` / `req1_op`  in  3  aluop.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU.
- `alu_op`  out  3  registered aluop to ALU.
- `alu_start`  out  1  one-cycle multiplier start pulse (wired to the ALU's `rst`).
- `alu_result`  in  WIDTH  ALU result.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that issued the response (0/1).
- `rsp_result`  out  WIDTH  captured result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: if any `reqN_valid`, select a winner. `reqN_ready` is high combinationally for the winner only. On that cycle latch a, b, op and id into issue registers, update `last_grant`, and go to ISSUE. With no valid request, stay in IDLE.
- Grant: only one valid requester → it wins. Both valid → the requester ≠ `last_grant` wins. `last_grant` resets to 1, so requester 0 wins first.
- ISSUE: `alu_a`/`alu_b`/`alu_op` always reflect the issue registers. If op == `MUL_OP`, assert `alu_start` this cycle only and load the counter with `MULT_LAT-1`. Otherwise load the counter with 0. Go to WAIT.
- WAIT: if counter == 0, capture `alu_result` into `rsp_result` and go to RESP. Otherwise decrement the counter.
- RESP: `rsp_valid`=1, and `rsp_id`/`rsp_result` are held stable. When `rsp_valid && rsp_ready`, go to IDLE. Both `reqN_ready` stay 0 outside IDLE.
- The ALU inputs are held constant from ISSUE through capture, so the multiplier sees stable operands.
- Reset mid-operation: the next state is IDLE and the in-flight operation is discarded, with no response. `alu_start` is 0 while `rst` is high; the top level ORs system reset into the ALU's `rst` separately.
- Reset values: `reqN_ready`=0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `alu_start`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `busy`=0.

## Timing
- Cycles are counted from the acceptance cycle T, where `reqN_valid && reqN_ready`.
- Non-multiply: ISSUE at T+1, capture at the edge ending T+2, `rsp_valid` high from T+3.
- Multiply: `alu_start` high during T+1 only. Capture at the end of T+1+`MULT_LAT`, `rsp_valid` high from T+2+`MULT_LAT`.
- Back-to-back: when the response handshakes in cycle R, the next acceptance is possible in cycle R+1. Steady-state throughput is one non-multiply op per 4 cycles.
- `rsp_ready` may be high before `rsp_valid`; a response handshakes in its first valid cycle.
- A requester that drops valid before ready is not served; requests are not sticky.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: grant is fixed priority, and requester 0 always wins when both are valid. `last_grant` is not implemented.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Bench uses the real `alu_with_mult` on the ALU side. Defaults throughout: `MULT_LAT`=34, `rsp_ready`=1 unless stated.
- req0 a=12, b=8, op=000, accepted at T → `rsp_valid` at T+3, `rsp_id`=0, `rsp_result` equals the ALU op-000 result for 12, 8.
- req1 a=12, b=8, op=010 → `alu_start` single pulse at T+1; `rsp_result`=96, `rsp_id`=1 at T+36; `busy` high T+1..T+36.
- Both requesters valid continuously after reset with op=000 → grants alternate 0,1,0,1 and `rsp_id` sequence is 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` the sequence is 0,0,0,0.
- a=-7, b=6, op=010 with `rsp_ready` held low 5 cycles after `rsp_valid` → `rsp_result`=-42 stable, no `reqN_ready` asserted, handshake on the 6th cycle, IDLE the next cycle.
- `rst` pulsed 10 cycles into a multiply → IDLE next cycle, `rsp_valid`=0, no response ever emitted. A following op=000 request is accepted and completes in 3 cycles.
